// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Elastic chain of STAGES pipeline registers with valid/ready backpressure,
//   per-stage flush and indexed stall with bubble insertion.
//
//   Parameters: WIDTH (payload bits), STAGES (>= 2), CNT_W (bubble counter bits)
//
//   Ports:
//     clk_i          clock, all state on rising edge
//     rst_ni         asynchronous active-low reset, clears all state
//     in_valid_i     upstream entry present
//     in_ready_o     chain accepts in_data_i this cycle (combinational)
//     in_data_i      upstream payload
//     out_valid_o    last stage holds a valid entry
//     out_ready_i    downstream consumes out_data_o this cycle
//     out_data_o     last-stage payload
//     stall_en_i     hold stages 0..stall_idx_i this cycle
//     stall_idx_i    highest held stage, clamped to STAGES-2
//     flush_i        flush_i[i] makes stage i capture a bubble
//     valid_vec_o    per-stage valid bits
//     occupancy_o    number of valid stages (combinational)
//     bubble_cnt_o   saturating count of stall-inserted bubbles
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5,
  parameter int CNT_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_data_o,
  input  logic                         stall_en_i,
  input  logic [$clog2(STAGES)-1:0]    stall_idx_i,
  input  logic [STAGES-1:0]            flush_i,
  output logic [STAGES-1:0]            valid_vec_o,
  output logic [$clog2(STAGES+1)-1:0]  occupancy_o,
  output logic [CNT_W-1:0]             bubble_cnt_o
);

  localparam int IDX_W = $clog2(STAGES);
  localparam int OCC_W = $clog2(STAGES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [CNT_W-1:0]  bubble_cnt_q;

  logic [STAGES-1:0] go_s;
  logic [STAGES-1:0] up_v_s;
  logic [WIDTH-1:0]  up_d_s [STAGES];
  logic [IDX_W-1:0]  k_s;
  logic              bub_s;
  logic [OCC_W-1:0]  occ_s;

  // Clamp the stall index so the bubble stage k+1 always exists.
  always_comb begin
    if (stall_idx_i >= LAST_IDX) begin
      k_s = LAST_IDX - IDX_W'(1);
    end else begin
      k_s = stall_idx_i;
    end
  end

  // Load enables. Unrolling go[i] = !v[i] | go[i+1] gives: stage i may load
  // unless every stage from i to the output is full and the output is
  // blocked. Walking a running AND avoids a self-referencing vector.
  // Stalled stages 0..k are then forced to hold.
  always_comb begin
    logic full_run;
    full_run = 1'b1;
    go_s     = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full_run = full_run & v_q[i];
      go_s[i]  = (out_ready_i | ~full_run) & ~(stall_en_i & (IDX_W'(i) <= k_s));
    end
  end

  // Source feeding each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    up_v_s    = {v_q[STAGES-2:0], in_valid_i};
    up_d_s[0] = in_data_i;
    for (int i = 1; i < STAGES; i++) begin
      up_d_s[i] = d_q[i-1];
    end
  end

  // Next-state selection in priority order: flush, hold, stall bubble, advance.
  // Payload is written only when a valid entry is loaded.
  always_comb begin
    bub_s = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      v_d[i] = v_q[i];
      d_d[i] = d_q[i];
      if (flush_i[i]) begin
        v_d[i] = 1'b0;
      end else if (!go_s[i]) begin
        v_d[i] = v_q[i];
      end else if (stall_en_i && (i == int'(k_s) + 1)) begin
        v_d[i] = 1'b0;
      end else begin
        v_d[i] = up_v_s[i];
        if (up_v_s[i]) begin
          d_d[i] = up_d_s[i];
        end else begin
          d_d[i] = d_q[i];
        end
      end
      // A bubble is counted whenever stage k+1 is free to load, even if a
      // flush on that stage takes priority over the bubble itself.
      bub_s = bub_s | (stall_en_i & go_s[i] & (i == int'(k_s) + 1));
    end
  end

  // Stage valid/payload registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  // Saturating bubble counter, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bubble_cnt_q <= '0;
    end else if (bub_s && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end else begin
      bubble_cnt_q <= bubble_cnt_q;
    end
  end

  // Population count of the valid bits.
  always_comb begin
    occ_s = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_s = occ_s + OCC_W'(v_q[i]);
    end
  end

  assign in_ready_o   = go_s[0];
  assign out_valid_o  = v_q[STAGES-1];
  assign out_data_o   = d_q[STAGES-1];
  assign valid_vec_o  = v_q;
  assign occupancy_o  = occ_s;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain: directed scenarios followed by random
// traffic, all compared cycle by cycle against a slot-level reference model.
module tb_pipe_stage_chain;

  localparam int W  = 32;
  localparam int S  = 5;
  localparam int CW = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          stall_en;
  logic [2:0]    stall_idx;
  logic [S-1:0]  flush;
  logic [S-1:0]  valid_vec;
  logic [2:0]    occupancy;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .stall_en_i   (stall_en),
    .stall_idx_i  (stall_idx),
    .flush_i      (flush),
    .valid_vec_o  (valid_vec),
    .occupancy_o  (occupancy),
    .bubble_cnt_o (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one slot (valid + payload) per stage, plus bubble count.
  bit           mv [S];
  logic [W-1:0] md [S];
  int           mbub;
  int           cyc;
  int           peak;
  int           seq;
  logic [W-1:0] got_q [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    mbub = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input logic iv, input logic [W-1:0] idat, input logic ordy,
                      input logic sen, input logic [2:0] sidx, input logic [S-1:0] fl,
                      output logic acc);
    bit           go [S];
    bit           nv [S];
    logic [W-1:0] nd [S];
    bit           avail;
    int           k;
    int           occ;
    logic [S-1:0] vv;
    @(negedge clk);
    in_valid  = iv;
    in_data   = idat;
    out_ready = ordy;
    stall_en  = sen;
    stall_idx = sidx;
    flush     = fl;
    #1;
    k = (sidx >= 3'd4) ? 3 : int'(sidx);
    // A stage can load if downstream can take it: the output is being
    // consumed or some stage from here to the output is empty.
    for (int i = 0; i < S; i++) begin
      avail = ordy;
      for (int j = i; j < S; j++) begin
        if (!mv[j]) avail = 1'b1;
      end
      go[i] = avail && !(sen && (i <= k));
    end
    occ = 0;
    for (int i = 0; i < S; i++) begin
      occ   += int'(mv[i]);
      vv[i]  = mv[i];
    end
    check_eq("in_ready",   64'(in_ready),   64'(go[0]));
    check_eq("out_valid",  64'(out_valid),  64'(mv[S-1]));
    check_eq("out_data",   64'(out_data),   64'(md[S-1]));
    check_eq("valid_vec",  64'(valid_vec),  64'(vv));
    check_eq("occupancy",  64'(occupancy),  64'(occ));
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'(mbub));
    acc = iv & in_ready;
    if (out_valid && ordy) got_q.push_back(out_data);
    if (int'(occupancy) > peak) peak = int'(occupancy);
    nv = mv;
    nd = md;
    for (int i = 0; i < S; i++) begin
      if (fl[i]) begin
        nv[i] = 1'b0;
      end else if (!go[i]) begin
        nv[i] = mv[i];
      end else if (sen && (i == k + 1)) begin
        nv[i] = 1'b0;
      end else if (i == 0) begin
        nv[0] = iv;
        if (iv) nd[0] = idat;
      end else begin
        nv[i] = mv[i-1];
        if (mv[i-1]) nd[i] = md[i-1];
      end
    end
    if (sen && go[k+1] && (mbub < CNT_SAT)) mbub++;
    mv = nv;
    md = nd;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) begin
      step(1'b1, W'(seq), ordy, 1'b0, 3'd0, '0, acc);
      if (acc) seq++;
    end
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 3'd0, '0, acc);
    end
  endtask

  initial begin
    logic acc;
    int   acc_c, out_c, c, nacc, base, hits;
    logic [W-1:0] lost0, lost1;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall_en = 1'b0; stall_idx = 3'd0; flush = '0;
    cyc = 0; peak = 0; seq = 1;
    model_reset();
    #12;
    check_eq("rst_out_valid",  64'(out_valid),  64'd0);
    check_eq("rst_out_data",   64'(out_data),   64'd0);
    check_eq("rst_valid_vec",  64'(valid_vec),  64'd0);
    check_eq("rst_occupancy",  64'(occupancy),  64'd0);
    check_eq("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    check_eq("rst_in_ready",   64'(in_ready),   64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream 1..8 with out_ready held high.
    got_q.delete(); seq = 1; acc_c = -1; out_c = -1; peak = 0;
    for (int i = 0; i < 14; i++) begin
      c = cyc;
      step(seq <= 8, W'(seq), 1'b1, 1'b0, 3'd0, '0, acc);
      if (acc && seq == 1) acc_c = c;
      if (acc) seq++;
      if (got_q.size() > 0 && out_c < 0) out_c = c;
    end
    check_eq("stream_latency", 64'(out_c - acc_c), 64'd5);
    check_eq("stream_count",   64'(got_q.size()), 64'd8);
    for (int i = 0; i < got_q.size(); i++) check_eq("stream_order", 64'(got_q[i]), 64'(i + 1));
    check_eq("stream_peak_occ", 64'(peak), 64'd5);

    // Backpressure: 10 cycles of out_ready=0, then pass-through and drain.
    got_q.delete(); seq = 1; nacc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'(seq), 1'b0, 1'b0, 3'd0, '0, acc);
      if (acc) begin nacc++; seq++; end
    end
    check_eq("bp_accepted", 64'(nacc), 64'd5);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, W'(seq), 1'b1, 1'b0, 3'd0, '0, acc);
    check_eq("bp_passthru_accept", 64'(acc), 64'd1);
    if (acc) seq++;
    drain(8);
    check_eq("bp_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < got_q.size(); i++) check_eq("bp_order", 64'(got_q[i]), 64'(i + 1));

    // One-cycle stall at index 1 inside a full stream.
    got_q.delete(); base = seq;
    feed(8, 1'b1);
    step(1'b1, W'(seq), 1'b1, 1'b1, 3'd1, '0, acc);
    check_eq("stall_no_accept", 64'(acc), 64'd0);
    if (acc) seq++;
    check_eq("stall_bubble_cnt", 64'(bubble_cnt), 64'd1);
    check_eq("stall_stage2_bubble", 64'(valid_vec[2]), 64'd0);
    feed(6, 1'b1);
    drain(8);
    check_eq("stall_count", 64'(got_q.size()), 64'(seq - base));
    for (int i = 0; i < got_q.size(); i++) check_eq("stall_order", 64'(got_q[i]), 64'(base + i));

    // Flush stages 0 and 1 for one cycle.
    got_q.delete(); base = seq;
    feed(8, 1'b1);
    lost1 = W'(seq);
    lost0 = W'(seq - 1);
    step(1'b1, W'(seq), 1'b1, 1'b0, 3'd0, 5'b00011, acc);
    check_eq("flush_accept", 64'(acc), 64'd1);
    if (acc) seq++;
    feed(6, 1'b1);
    drain(8);
    check_eq("flush_count", 64'(got_q.size()), 64'(seq - base - 2));
    hits = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] == lost0 || got_q[i] == lost1) hits++;
    end
    check_eq("flush_dropped", 64'(hits), 64'd0);

    // Flush on stage 2 coinciding with stall index 1.
    feed(8, 1'b1);
    step(1'b1, W'(seq), 1'b1, 1'b1, 3'd1, 5'b00100, acc);
    if (acc) seq++;
    check_eq("flstall_stage2", 64'(valid_vec[2]), 64'd0);
    check_eq("flstall_bubble_cnt", 64'(bubble_cnt), 64'd2);
    drain(8);

    // Asynchronous reset with four entries in flight.
    feed(4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; stall_en = 1'b0; flush = '0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid",  64'(out_valid),  64'd0);
    check_eq("arst_valid_vec",  64'(valid_vec),  64'd0);
    check_eq("arst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    check_eq("arst_occupancy",  64'(occupancy),  64'd0);
    check_eq("arst_out_data",   64'(out_data),   64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete(); out_c = -1;
    acc_c = cyc;
    step(1'b1, 32'h0000_000A, 1'b1, 1'b0, 3'd0, '0, acc);
    check_eq("arst_accept", 64'(acc), 64'd1);
    for (int i = 0; i < 8; i++) begin
      c = cyc;
      step(1'b0, '0, 1'b1, 1'b0, 3'd0, '0, acc);
      if (got_q.size() > 0 && out_c < 0) out_c = c;
    end
    check_eq("arst_latency", 64'(out_c - acc_c), 64'd5);
    check_eq("arst_count",   64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check_eq("arst_data", 64'(got_q[0]), 64'h0000_000A);

    // Random traffic including stalls, flushes and counter saturation.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0) ? S'($urandom) : S'(0), acc);
    end
    drain(8);
    check_eq("rand_bubble_sat", 64'(bubble_cnt), 64'(CNT_SAT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised, elastic pipeline-register chain. It generalises the fixed IF/ID → ID/EX → EX/MEM → MEM/WB register set of the 5-stage CPU into one block with:
- configurable width and depth;
- valid/ready backpressure;
- per-stage flush;
- indexed stall with bubble insertion.

The CPU datapath instantiates it between its front end and its retire logic. The hazard unit drives `stall_*`; the branch/jump resolution drives `flush`.

## Interface
- WIDTH, 32, payload bits per stage
- STAGES, 5, number of register stages (≥2); stage 0 is input-side, stage STAGES-1 drives the output
- CNT_W, 16, width of the bubble performance counter
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  upstream entry present
- in_ready  out  1  chain accepts in_data this cycle (combinational)
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage STAGES-1 holds a valid entry
- out_ready  in  1  downstream consumes out_data this cycle
- out_data  out  WIDTH  stage STAGES-1 payload
- stall_en  in  1  hold stages 0..stall_idx this cycle
- stall_idx  in  $clog2(STAGES)  highest held stage; values ≥STAGES-1 are treated as STAGES-2
- flush  in  STAGES  flush[i]=1 makes stage i capture a bubble at this edge
- valid_vec  out  STAGES  per-stage valid bits
- occupancy  out  $clog2(STAGES+1)  popcount of valid_vec (combinational)
- bubble_cnt  out  CNT_W  saturating count of stall-inserted bubbles

## Operation
- Per-stage state: `v[i]` (valid) and `d[i]` (payload).
- Load enable, evaluated from the output backwards:
  - `go[S-1] = !v[S-1] | out_ready`
  - `go[i] = !v[i] | go[i+1]`
  - Stall override: when stall_en, `go[i]=0` for every i ≤ k, where k is the clamped stall_idx.
- Outputs: `in_ready = go[0]`; `out_valid = v[S-1]`; `out_data = d[S-1]`.
- Next state of stage i, applied in this priority order:
  1. flush[i] → `v[i]=0`. The current contents of stage i still advance to i+1 if `go[i+1]`; otherwise they are dropped.
  2. !go[i] → hold.
  3. stall_en and i == k+1 → load a bubble (`v[i]=0`) and increment bubble_cnt. If go[k+1] is low, no bubble is counted.
  4. i == 0 → `v[0]=in_valid`, `d[0]=in_data`.
  5. Otherwise → `v[i]=v[i-1]`, `d[i]=d[i-1]`.
- `d[i]` is written only when a valid entry is loaded. Bubbles leave `d[i]` unchanged.
- A handshake occurs on in_valid & in_ready, and separately on out_valid & out_ready. Entries never reorder, duplicate or vanish except by flush.
- bubble_cnt saturates at 2^CNT_W-1. It is cleared only by reset.

## Timing
- Reset value (while reset low, immediately and asynchronously): all `v`/`d` = 0, out_valid=0, out_data=0, valid_vec=0, occupancy=0, bubble_cnt=0.
- in_ready=1 after reset whenever stall_en=0.
- Latency: an entry accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. it is consumed no earlier than STAGES cycles after acceptance.
- Throughput: 1 entry/cycle with out_ready=1 and no stall/flush.
- in_ready depends combinationally on out_ready, stall_en and stall_idx. There is no combinational path from in_valid to in_ready.
- Full chain with out_ready=0: in_ready=0. Consuming the output and accepting a new input in the same cycle is legal (pass-through).
- Empty chain: out_valid=0. An accepted entry is never bypassed to the output combinationally.
- Asserting reset mid-operation discards all entries with no partial state. The first edge after release behaves as from empty.

## Test plan
- STAGES=5, WIDTH=32, stream 0x1..0x8, out_ready=1 → 0x1 on output 5 cycles after its accept, then one per cycle in order; occupancy peaks at 5.
- Hold out_ready=0 for 10 cycles while in_valid=1 → exactly 5 accepted and in_ready=0. Then out_ready=1 → 0x1..0x5 drained in order, no loss or duplication, in_ready high the same cycle.
- Full stream; stall_en=1 with stall_idx=1 for one cycle → stages 0–1 hold, stage 2 goes invalid, a one-cycle gap appears on the output, bubble_cnt=1.
- Stream with flush=5'b00011 for one cycle → the entry accepted that cycle and the entry previously in stage 0 never appear at the output; occupancy drops by 2 over following cycles.
- flush[2]=1 together with stall_en=1, stall_idx=1 → stage 2 invalid (flush wins), bubble_cnt still increments by 1.
- Assert reset with 4 entries in flight → out_valid, valid_vec and bubble_cnt all 0 immediately. After release, new input 0xA emerges after 5 cycles.
